// File: rtl/distribute_1x2_lane_buffer_seq.sv
// Two independent first-word-fall-through FIFOs behind the 1x2 distribute switch.
// A packet is accepted only when both lanes have space, so a multicast packet never splits.
module distribute_1x2_lane_buffer_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int CMD_WIDTH  = 1,
  parameter int FIFO_DEPTH = 2,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              i_valid,
  input  logic [2*DATA_WIDTH-1:0] i_data_bus,
  input  logic [2*CMD_WIDTH-1:0]  i_cmd,
  output logic                    o_ready,
  output logic [1:0]              o_valid,
  output logic [2*DATA_WIDTH-1:0] o_data_bus,
  output logic [2*CMD_WIDTH-1:0]  o_cmd,
  input  logic [1:0]              i_ready,
  output logic [2*CNT_W-1:0]      o_count
);

  localparam int ENTRY_W = CMD_WIDTH + DATA_WIDTH;

  logic [1:0] lane_space;
  logic [1:0] push;
  logic [1:0] pop;

  // Readiness depends only on registered counts, never on i_ready.
  assign o_ready = &lane_space;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] head;

    assign lane_space[gi] = (count_q < CNT_W'(FIFO_DEPTH));
    assign o_valid[gi]    = (count_q != '0);
    assign push[gi]       = i_valid[gi] & o_ready;
    assign pop[gi]        = o_valid[gi] & i_ready[gi];
    assign head           = mem_q[rptr_q];

    // Empty lanes present all-zero dummy data instead of stale storage.
    assign o_data_bus[gi*DATA_WIDTH +: DATA_WIDTH] =
      o_valid[gi] ? head[DATA_WIDTH-1:0] : '0;
    assign o_cmd[gi*CMD_WIDTH +: CMD_WIDTH] =
      o_valid[gi] ? head[ENTRY_W-1:DATA_WIDTH] : '0;
    assign o_count[gi*CNT_W +: CNT_W] = count_q;

    always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
      if (push[gi]) begin
        mem_d[wptr_q] = {i_cmd[gi*CMD_WIDTH +: CMD_WIDTH],
                         i_data_bus[gi*DATA_WIDTH +: DATA_WIDTH]};
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop[gi]) begin
        rptr_d = rptr_q + 1'b1;
      end
    end

    // Storage needs no reset: a zero count masks whatever it holds.
    always_ff @(posedge clk) begin
      mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
      end
    end
  end

endmodule
